// File: rtl/kmac_enc_pkg.sv
// kmac_enc_pkg: shared types and byte-select helper for the SP 800-185 encode sequencer
package kmac_enc_pkg;
  localparam int MAX_W = 2040;
  typedef enum logic {ENC_LEFT = 1'b0, ENC_RIGHT = 1'b1} enc_mode_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SIZE, ST_PREFIX, ST_DATA, ST_SUFFIX, ST_DONE} enc_state_t;
  function automatic logic [7:0] byte_sel(input logic [MAX_W-1:0] value, input logic [7:0] idx);
    return value[{idx, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/kmac_byte_len.sv
// kmac_byte_len: number of significant bytes of value_i, minimum 1
module kmac_byte_len #(
  parameter int VAL_W = 32,
  localparam int NB = VAL_W / 8,
  localparam int CW = $clog2(NB + 1)
) (
  input  logic [VAL_W-1:0] value_i,
  output logic [CW-1:0]    n_o
);
  always_comb begin
    n_o = CW'(1);
    for (int i = 0; i < NB; i++) n_o = (value_i[i*8 +: 8] != 8'h00) ? CW'(i + 1) : n_o;
  end
endmodule

// File: rtl/kmac_encode_seq.sv
// kmac_encode_seq: serialises left_encode/right_encode framing bytes onto a valid/ready byte stream
module kmac_encode_seq import kmac_enc_pkg::*; #(
  parameter int VAL_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [VAL_W-1:0] value_i,
  output logic             busy_o,
  output logic [7:0]       byte_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             done_o
);
  localparam int NB = VAL_W / 8;
  localparam int CW = $clog2(NB + 1);
  enc_state_t state_q, state_d;
  enc_mode_t mode_q, mode_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [CW-1:0] n_q, n_d, idx_q, idx_d, n_calc;
  logic hs;
  kmac_byte_len #(.VAL_W(VAL_W)) u_len (.value_i(val_q), .n_o(n_calc));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= ENC_LEFT;
      val_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
    end
  end
  assign hs = valid_o & ready_i;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    val_d   = val_q;
    n_d     = n_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_SIZE;
        val_d   = value_i;
        mode_d  = enc_mode_t'(mode_i);
      end
      ST_SIZE: begin
        n_d     = n_calc;
        idx_d   = n_calc - 1'b1;
        state_d = (mode_q == ENC_LEFT) ? ST_PREFIX : ST_DATA;
      end
      ST_PREFIX: state_d = hs ? ST_DATA : state_q;
      ST_DATA: if (hs) begin
        if (idx_q == '0) state_d = (mode_q == ENC_RIGHT) ? ST_SUFFIX : ST_DONE;
        else idx_d = idx_q - 1'b1;
      end
      ST_SUFFIX: state_d = hs ? ST_DONE : state_q;
      default: state_d = ST_IDLE;
    endcase
  end
  // outputs decode from registered state only, so ready_i never reaches valid_o
  assign valid_o = state_q inside {ST_PREFIX, ST_DATA, ST_SUFFIX};
  assign busy_o  = state_q != ST_IDLE;
  assign done_o  = state_q == ST_DONE;
  assign last_o  = (state_q == ST_SUFFIX) || (state_q == ST_DATA && idx_q == '0 && mode_q == ENC_LEFT);
  assign byte_o  = (state_q == ST_DATA) ? byte_sel(MAX_W'(val_q), 8'(idx_q)) :
                   (state_q inside {ST_PREFIX, ST_SUFFIX}) ? 8'(n_q) : 8'h00;
endmodule

// File: tb/tb_kmac_encode_seq.sv
// tb_kmac_encode_seq: randomized self-checking bench against a queue-based encoding model
module tb_kmac_encode_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic mode_i = 1'b0;
  logic [31:0] value_i = '0;
  logic ready_i = 1'b0;
  logic busy_o, valid_o, last_o, done_o;
  logic [7:0] byte_o;
  int n_checks = 0;
  int n_fail = 0;
  kmac_encode_seq #(.VAL_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .value_i(value_i),
    .busy_o(busy_o), .byte_o(byte_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_last"}, last_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_byte"}, byte_o, 0);
  endtask
  // rk: 0 ready always high, 1 random ready, 2 ready pattern 1-0-0 repeating
  task automatic run_seq(input logic m, input logic [31:0] v, input int rk, input bit inj);
    logic [7:0] q[$];
    logic [31:0] t;
    int n, cyc;
    n = 0;
    t = v;
    do begin n++; t = t >> 8; end while (t != 0);
    if (!m) q.push_back(8'(n));
    for (int i = n - 1; i >= 0; i--) q.push_back(8'(v >> (8 * i)));
    if (m) q.push_back(8'(n));
    check("pre_busy", busy_o, 0);
    start_i = 1'b1;
    mode_i = m;
    value_i = v;
    @(negedge clk);
    start_i = 1'b0;
    value_i = $urandom;
    check("size_valid", valid_o, 0);
    check("size_busy", busy_o, 1);
    check("size_byte", byte_o, 0);
    @(negedge clk);
    check("first_valid", valid_o, 1);
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      ready_i = (rk == 0) ? 1'b1 : (rk == 1) ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
      start_i = inj && cyc == 1;
      value_i = ~v;
      mode_i = ~m;
      check("valid", valid_o, 1);
      check("byte", byte_o, q[0]);
      check("last", last_o, q.size() == 1);
      check("done_early", done_o, 0);
      if (ready_i) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    ready_i = 1'b0;
    check("stream_len", q.size(), 0);
    check("done", done_o, 1);
    check("done_valid", valid_o, 0);
    check("done_busy", busy_o, 1);
    check("done_byte", byte_o, 0);
    start_i = 1'b1;
    value_i = $urandom;
    @(negedge clk);
    start_i = 1'b0;
    check("post_done", done_o, 0);
    check("post_busy", busy_o, 0);
    check("post_valid", valid_o, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(1'b1, 32'd0, 0, 1'b0);
    run_seq(1'b1, 32'd256, 0, 1'b0);
    run_seq(1'b0, 32'h0102_0304, 0, 1'b0);
    run_seq(1'b0, 32'd136, 2, 1'b0);
    run_seq(1'b0, 32'hDEAD_BEEF, 0, 1'b1);
    run_seq(1'b1, 32'h00C0_FFEE, 0, 1'b1);
    run_seq(1'b1, 32'hFFFF_FFFF, 1, 1'b0);
    run_seq(1'b0, 32'h0000_00FF, 1, 1'b0);
    run_seq(1'b1, 32'h0001_0000, 2, 1'b0);
    for (int k = 0; k < 30; k++)
      run_seq(1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 31), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    start_i = 1'b1;
    mode_i = 1'b0;
    value_i = 32'hAABB_CCDD;
    ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", valid_o, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk);
    check_idle_outputs("rst_hold");
    rst_n = 1'b1;
    ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("after_rst");
    end
    run_seq(1'b1, 32'h0012_3456, 0, 1'b0);
    run_seq(1'b0, 32'd0, 2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
